// File: rtl/chunk_head_pipe_pkg.sv
// chunk_head_pipe shared defaults and FSM state encoding.
// Imported by the interface, the accumulator and the top.
package chunk_head_pipe_pkg;

   localparam int WBW_DEF    = 32;
   localparam int N_ICFG_DEF = 4;
   localparam int VDIM_DEF   = 6;
   localparam int DIM_DEF    = 4;
   localparam int SF_BW_DEF  = 8;
   localparam int SS_BW_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

endpackage

// File: rtl/chunk_head_pipe_if.sv
// Offset-pair input and memory-offset output handshakes.
// master drives the pair and takes offsets; slave is the generator.
interface chunk_head_pipe_if
   import chunk_head_pipe_pkg::*;
#(
   parameter int WBW     = WBW_DEF,
   parameter int N_ICFG  = N_ICFG_DEF,
   parameter int VDIM    = VDIM_DEF,
   parameter int DIM     = DIM_DEF,
   parameter int ICFG_BW = $clog2(N_ICFG + 1)
);

   logic                      i_abofs_rdy;
   logic                      i_abofs_ack;
   logic [VDIM-1:0][WBW-1:0]  i_bofs;
   logic [VDIM-1:0][WBW-1:0]  i_aofs;
   logic [ICFG_BW-1:0]        i_beg;
   logic [ICFG_BW-1:0]        i_end;
   logic [N_ICFG-1:0]         i_skip;
   logic                      o_mofs_rdy;
   logic                      o_mofs_ack;
   logic [DIM-1:0][WBW-1:0]   o_mofs;
   logic [ICFG_BW-1:0]        o_id;
   logic                      o_last;

   modport master (
      output i_abofs_rdy, i_bofs, i_aofs,
      output i_beg, i_end, i_skip, o_mofs_ack,
      input  i_abofs_ack, o_mofs_rdy,
      input  o_mofs, o_id, o_last
   );

   modport slave (
      input  i_abofs_rdy, i_bofs, i_aofs,
      input  i_beg, i_end, i_skip, o_mofs_ack,
      output i_abofs_ack, o_mofs_rdy,
      output o_mofs, o_id, o_last
   );

endinterface

// File: rtl/chunk_head_pipe_nd_shuf_accum.sv
// Base vector plus two shuffled addend vectors folded into DIM sums.
// Several addends may land on one dim; all sums wrap at WBW.
module nd_shuf_accum
   import chunk_head_pipe_pkg::*;
#(
   parameter int WBW    = WBW_DEF,
   parameter int VDIM   = VDIM_DEF,
   parameter int DIM    = DIM_DEF,
   parameter int DIM_BW = $clog2(DIM)
) (
   input  logic [DIM-1:0][WBW-1:0]     base,
   input  logic [VDIM-1:0][WBW-1:0]    b_add,
   input  logic [VDIM-1:0][DIM_BW-1:0] b_shuf,
   input  logic [VDIM-1:0][WBW-1:0]    a_add,
   input  logic [VDIM-1:0][DIM_BW-1:0] a_shuf,
   output logic [DIM-1:0][WBW-1:0]     sum
);

   always_comb begin
      sum = base;
      for (int d = 0; d < DIM; d++) begin
         for (int i = 0; i < VDIM; i++) begin
            if (b_shuf[i] == DIM_BW'(d))
               sum[d] = sum[d] + b_add[i];
            if (a_shuf[i] == DIM_BW'(d))
               sum[d] = sum[d] + a_add[i];
         end
      end
   end

endmodule

// File: rtl/chunk_head_pipe.sv
// Chunk-head address generator: walks unskipped config ids of a range
// and emits one shuffled, strided DIM-wide memory offset per id.
module chunk_head_pipe
   import chunk_head_pipe_pkg::*;
#(
   parameter int WBW       = WBW_DEF,
   parameter int N_ICFG    = N_ICFG_DEF,
   parameter int VDIM      = VDIM_DEF,
   parameter int DIM       = DIM_DEF,
   parameter int SF_BW     = SF_BW_DEF,
   parameter int SS_BW     = SS_BW_DEF,
   parameter int MUL_STAGE = 0,
   parameter int ICFG_BW   = $clog2(N_ICFG + 1),
   parameter int DIM_BW    = $clog2(DIM)
) (
   input  logic i_clk,
   input  logic i_rst,
   chunk_head_pipe_if.slave bus,
   input  logic [N_ICFG-1:0][DIM-1:0][WBW-1:0]     i_global_mofs,
   input  logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0] i_global_bshufs,
   input  logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0] i_global_ashufs,
   input  logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]  i_bstrides_frac,
   input  logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]  i_astrides_frac,
   input  logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]  i_bstrides_shamt,
   input  logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]  i_astrides_shamt
);

   localparam int IX_BW = (N_ICFG > 1) ? $clog2(N_ICFG) : 1;

   typedef logic [VDIM-1:0][WBW-1:0] vec_t;
   typedef logic [DIM-1:0][WBW-1:0]  mofs_t;

   state_t             state;
   vec_t               bofs_q, aofs_q;
   vec_t               pb_q, pa_q;
   logic [ICFG_BW-1:0] cur_id;
   mofs_t              mofs_q;
   logic [ICFG_BW-1:0] id_q;
   logic               last_q;
   logic               rdy_q;

   logic [ICFG_BW:0]   nxt_srch, fol_srch;
   logic [ICFG_BW-1:0] nxt_from, nxt_id, fol_from, acc_id;
   logic               nxt_ok, fol_ok;
   logic [IX_BW-1:0]   nxt_ix, acc_ix;
   vec_t               src_b, src_a, prod_b, prod_a;
   vec_t               acc_b, acc_a;
   mofs_t              acc_sum;
   logic               adv, fin;

   // Lowest unskipped id in [from, lim); MSB flags that one exists.
   function automatic logic [ICFG_BW:0] find_id(
      input logic [ICFG_BW-1:0] from,
      input logic [ICFG_BW-1:0] lim,
      input logic [N_ICFG-1:0]  skip
   );
      logic [ICFG_BW:0] r;
      r = '0;
      for (int k = N_ICFG - 1; k >= 0; k--) begin
         if (ICFG_BW'(k) >= from && ICFG_BW'(k) < lim && !skip[k])
            r = {1'b1, ICFG_BW'(k)};
      end
      return r;
   endfunction

   assign nxt_from = (state == ST_IDLE) ? bus.i_beg : id_q + ICFG_BW'(1);
   assign nxt_srch = find_id(nxt_from, bus.i_end, bus.i_skip);
   assign nxt_ok   = nxt_srch[ICFG_BW];
   assign nxt_id   = nxt_srch[ICFG_BW-1:0];
   assign nxt_ix   = nxt_id[IX_BW-1:0];

   // With the product stage the id in flight sits in cur_id during CALC.
   assign acc_id   = (MUL_STAGE != 0) ? cur_id : nxt_id;
   assign acc_ix   = acc_id[IX_BW-1:0];
   assign fol_from = acc_id + ICFG_BW'(1);
   assign fol_srch = find_id(fol_from, bus.i_end, bus.i_skip);
   assign fol_ok   = fol_srch[ICFG_BW];

   assign src_b = (state == ST_IDLE) ? bus.i_bofs : bofs_q;
   assign src_a = (state == ST_IDLE) ? bus.i_aofs : aofs_q;

   always_comb begin
      prod_b = '0;
      prod_a = '0;
      for (int i = 0; i < VDIM; i++) begin
         prod_b[i] = (src_b[i] * WBW'(i_bstrides_frac[nxt_ix][i]))
                     << i_bstrides_shamt[nxt_ix][i];
         prod_a[i] = (src_a[i] * WBW'(i_astrides_frac[nxt_ix][i]))
                     << i_astrides_shamt[nxt_ix][i];
      end
   end

   assign acc_b = (MUL_STAGE != 0) ? pb_q : prod_b;
   assign acc_a = (MUL_STAGE != 0) ? pa_q : prod_a;

   nd_shuf_accum #(
      .WBW    (WBW),
      .VDIM   (VDIM),
      .DIM    (DIM),
      .DIM_BW (DIM_BW)
   ) u_accum (
      .base   (i_global_mofs[acc_ix]),
      .b_add  (acc_b),
      .b_shuf (i_global_bshufs[acc_ix]),
      .a_add  (acc_a),
      .a_shuf (i_global_ashufs[acc_ix]),
      .sum    (acc_sum)
   );

   assign adv = (state == ST_IDLE && bus.i_abofs_rdy && nxt_ok)
             || (state == ST_OUT && bus.o_mofs_ack && !last_q);
   assign fin = state == ST_OUT && bus.o_mofs_ack && last_q;

   assign bus.i_abofs_ack = fin
      || (state == ST_IDLE && bus.i_abofs_rdy && !nxt_ok);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= ST_IDLE;
         bofs_q <= '0;
         aofs_q <= '0;
         pb_q   <= '0;
         pa_q   <= '0;
         cur_id <= '0;
         mofs_q <= '0;
         id_q   <= '0;
         last_q <= 1'b0;
         rdy_q  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (adv) begin
                  bofs_q <= bus.i_bofs;
                  aofs_q <= bus.i_aofs;
               end
            end
            ST_CALC: begin
               mofs_q <= acc_sum;
               id_q   <= cur_id;
               last_q <= !fol_ok;
               rdy_q  <= 1'b1;
               state  <= ST_OUT;
            end
            ST_OUT: begin
               if (fin) begin
                  rdy_q <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (adv) begin
            if (MUL_STAGE != 0) begin
               pb_q   <= prod_b;
               pa_q   <= prod_a;
               cur_id <= nxt_id;
               rdy_q  <= 1'b0;
               state  <= ST_CALC;
            end else begin
               mofs_q <= acc_sum;
               id_q   <= nxt_id;
               last_q <= !fol_ok;
               rdy_q  <= 1'b1;
               state  <= ST_OUT;
            end
         end
      end
   end

   assign bus.o_mofs_rdy = rdy_q;
   assign bus.o_mofs     = mofs_q;
   assign bus.o_id       = id_q;
   assign bus.o_last     = last_q;

endmodule

// File: tb/tb_chunk_head_pipe.sv
// Bench for chunk_head_pipe: one instance per MUL_STAGE setting,
// random ranges/config checked against a range-walking reference model.
module tb_chunk_head_pipe;

   localparam int WBW     = 32;
   localparam int N_ICFG  = 4;
   localparam int VDIM    = 6;
   localparam int DIM     = 4;
   localparam int SF_BW   = 8;
   localparam int SS_BW   = 4;
   localparam int ICFG_BW = $clog2(N_ICFG + 1);
   localparam int DIM_BW  = $clog2(DIM);

   typedef logic [DIM-1:0][WBW-1:0] mofs_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N_ICFG-1:0][DIM-1:0][WBW-1:0]     gm;
   logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0] bsh, ash;
   logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]  bfr, afr;
   logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]  bsa, asa;

   logic                     abofs_rdy, mofs_ack;
   logic [VDIM-1:0][WBW-1:0] bofs, aofs;
   logic [ICFG_BW-1:0]       beg, en;
   logic [N_ICFG-1:0]        skip;
   int                       sel;

   logic               abofs_ack, mofs_rdy, o_last;
   mofs_t              mofs;
   logic [ICFG_BW-1:0] o_id;

   int    errors = 0;
   int    checks = 0;
   mofs_t exp_m[$];
   int    exp_i[$];
   mofs_t first_mofs;

   chunk_head_pipe_if #(.WBW(WBW), .N_ICFG(N_ICFG), .VDIM(VDIM),
      .DIM(DIM), .ICFG_BW(ICFG_BW)) b0 ();
   chunk_head_pipe_if #(.WBW(WBW), .N_ICFG(N_ICFG), .VDIM(VDIM),
      .DIM(DIM), .ICFG_BW(ICFG_BW)) b1 ();

   assign b0.i_abofs_rdy = abofs_rdy && sel == 0;
   assign b1.i_abofs_rdy = abofs_rdy && sel == 1;
   assign b0.o_mofs_ack  = mofs_ack && sel == 0;
   assign b1.o_mofs_ack  = mofs_ack && sel == 1;
   assign b0.i_bofs = bofs;
   assign b1.i_bofs = bofs;
   assign b0.i_aofs = aofs;
   assign b1.i_aofs = aofs;
   assign b0.i_beg  = beg;
   assign b1.i_beg  = beg;
   assign b0.i_end  = en;
   assign b1.i_end  = en;
   assign b0.i_skip = skip;
   assign b1.i_skip = skip;

   assign abofs_ack = sel == 1 ? b1.i_abofs_ack : b0.i_abofs_ack;
   assign mofs_rdy  = sel == 1 ? b1.o_mofs_rdy : b0.o_mofs_rdy;
   assign mofs      = sel == 1 ? b1.o_mofs : b0.o_mofs;
   assign o_id      = sel == 1 ? b1.o_id : b0.o_id;
   assign o_last    = sel == 1 ? b1.o_last : b0.o_last;

   chunk_head_pipe #(.WBW(WBW), .N_ICFG(N_ICFG), .VDIM(VDIM), .DIM(DIM),
      .SF_BW(SF_BW), .SS_BW(SS_BW), .MUL_STAGE(0)) u0 (
      .i_clk(clk), .i_rst(rst), .bus(b0),
      .i_global_mofs(gm), .i_global_bshufs(bsh), .i_global_ashufs(ash),
      .i_bstrides_frac(bfr), .i_astrides_frac(afr),
      .i_bstrides_shamt(bsa), .i_astrides_shamt(asa));

   chunk_head_pipe #(.WBW(WBW), .N_ICFG(N_ICFG), .VDIM(VDIM), .DIM(DIM),
      .SF_BW(SF_BW), .SS_BW(SS_BW), .MUL_STAGE(1)) u1 (
      .i_clk(clk), .i_rst(rst), .bus(b1),
      .i_global_mofs(gm), .i_global_bshufs(bsh), .i_global_ashufs(ash),
      .i_bstrides_frac(bfr), .i_astrides_frac(afr),
      .i_bstrides_shamt(bsa), .i_astrides_shamt(asa));

   // Expected item list: every unskipped id of [beg, end) in order.
   function automatic void build_exp();
      mofs_t m;
      logic [WBW-1:0] t;
      exp_m.delete();
      exp_i.delete();
      for (int k = 0; k < N_ICFG; k++) begin
         if (k >= int'(beg) && k < int'(en) && !skip[k]) begin
            for (int d = 0; d < DIM; d++) begin
               m[d] = gm[k][d];
               for (int i = 0; i < VDIM; i++) begin
                  if (int'(bsh[k][i]) == d) begin
                     t = bofs[i] * {24'd0, bfr[k][i]};
                     m[d] = m[d] + (t << bsa[k][i]);
                  end
                  if (int'(ash[k][i]) == d) begin
                     t = aofs[i] * {24'd0, afr[k][i]};
                     m[d] = m[d] + (t << asa[k][i]);
                  end
               end
            end
            exp_m.push_back(m);
            exp_i.push_back(k);
         end
      end
   endfunction

   task automatic rand_cfg();
      for (int k = 0; k < N_ICFG; k++) begin
         for (int d = 0; d < DIM; d++) gm[k][d] = $urandom;
         for (int i = 0; i < VDIM; i++) begin
            bsh[k][i] = DIM_BW'($urandom_range(DIM - 1));
            ash[k][i] = DIM_BW'($urandom_range(DIM - 1));
            bfr[k][i] = SF_BW'($urandom);
            afr[k][i] = SF_BW'($urandom);
            bsa[k][i] = SS_BW'($urandom);
            asa[k][i] = SS_BW'($urandom);
         end
      end
   endtask

   task automatic unit_cfg();
      for (int k = 0; k < N_ICFG; k++) begin
         for (int d = 0; d < DIM; d++) gm[k][d] = $urandom;
         for (int i = 0; i < VDIM; i++) begin
            bsh[k][i] = DIM_BW'(i % DIM);
            ash[k][i] = DIM_BW'(i % DIM);
            bfr[k][i] = 1;
            afr[k][i] = 1;
            bsa[k][i] = 0;
            asa[k][i] = 0;
         end
      end
   endtask

   task automatic run_txn(input int stall_pct);
      int n, got, cyc, ref_cyc, lat;
      bit waiting, done, held_v, mack, is_last, xack;
      mofs_t held_m;
      logic [ICFG_BW-1:0] held_id;
      logic held_last;
      build_exp();
      n = exp_m.size();
      got = 0; cyc = 0; ref_cyc = 0;
      waiting = 1; done = 0; held_v = 0;
      held_m = '0; held_id = '0; held_last = 0;
      lat = 1 + sel;
      @(negedge clk);
      abofs_rdy = 1'b1;
      while (!done) begin
         mack = mofs_rdy && ($urandom_range(99) >= stall_pct);
         mofs_ack = mack;
         #1;
         if (cyc >= 1)
            for (int i = 0; i < VDIM; i++) bofs[i] = $urandom;
         if (held_v) begin
            checks++;
            if (mofs_rdy !== 1'b1 || mofs !== held_m
                || o_id !== held_id || o_last !== held_last) begin
               errors++;
               $display("FAIL stall_hold: rdy=%b id=%0d last=%b mofs=%h, required rdy=1 id=%0d last=%b mofs=%h",
                  mofs_rdy, o_id, o_last, mofs, held_id, held_last, held_m);
            end
            held_v = 0;
         end
         if (mofs_rdy === 1'b1 && waiting) begin
            checks++;
            if (cyc - ref_cyc != lat) begin
               errors++;
               $display("FAIL latency: %0d cycles, required %0d",
                  cyc - ref_cyc, lat);
            end
            waiting = 0;
         end
         is_last = 0;
         if (mofs_rdy === 1'b1 && mack) begin
            checks++;
            if (got >= n) begin
               errors++;
               $display("FAIL extra_item: id=%0d, required no item", o_id);
            end else if (mofs !== exp_m[got] || int'(o_id) != exp_i[got]
                         || o_last !== (got == n - 1)) begin
               errors++;
               $display("FAIL item%0d: id=%0d last=%b mofs=%h, required id=%0d last=%b mofs=%h",
                  got, o_id, o_last, mofs, exp_i[got], got == n - 1, exp_m[got]);
            end
            if (got == 0) first_mofs = mofs;
            is_last = (got == n - 1);
            got++;
            if (!is_last) begin
               waiting = 1;
               ref_cyc = cyc;
            end
         end else if (mofs_rdy === 1'b1) begin
            held_v = 1;
            held_m = mofs;
            held_id = o_id;
            held_last = o_last;
         end
         xack = (n == 0 && cyc == 0) || is_last;
         checks++;
         if (abofs_ack !== xack) begin
            errors++;
            $display("FAIL abofs_ack cyc%0d: %b, required %b",
               cyc, abofs_ack, xack);
         end
         if (abofs_ack === 1'b1 || xack) done = 1;
         if (cyc >= 400) begin
            errors++;
            $display("FAIL timeout: %0d of %0d items", got, n);
            done = 1;
         end
         @(negedge clk);
         cyc++;
      end
      abofs_rdy = 1'b0;
      mofs_ack = 1'b0;
      checks++;
      if (got != n) begin
         errors++;
         $display("FAIL item_count: %0d, required %0d", got, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         checks++;
         if ({mofs_rdy, abofs_ack, o_last} !== 3'b000 || o_id !== '0
             || mofs !== '0) begin
            errors++;
            $display("FAIL reset_state%0d: rdy=%b ack=%b last=%b id=%0d mofs=%h, required all 0",
               s, mofs_rdy, abofs_ack, o_last, o_id, mofs);
         end
      end
      rst = 1'b0;
      sel = 0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      sel = 0;
      unit_cfg();
      for (int i = 0; i < VDIM; i++) begin
         bofs[i] = WBW'(i + 1);
         aofs[i] = '0;
      end
      beg = 0; en = 3; skip = '0;
      run_txn(0);
      for (int i = 0; i < VDIM; i++) bofs[i] = WBW'(i + 1);
      skip = 4'b0010;
      run_txn(0);
   endtask

   task automatic test_empty();
      for (int s = 0; s < 2; s++) begin
         sel = s;
         rand_cfg();
         beg = 2; en = 2; skip = '0;
         run_txn(30);
         beg = 1; en = 3; skip = 4'b0110;
         run_txn(30);
         beg = 3; en = 1; skip = '0;
         run_txn(30);
         repeat (3) begin
            @(negedge clk);
            #1;
            checks++;
            if (mofs_rdy !== 1'b0) begin
               errors++;
               $display("FAIL empty_no_out%0d: rdy=%b, required 0", s, mofs_rdy);
            end
         end
      end
   endtask

   task automatic test_stride();
      logic [WBW-1:0] e;
      for (int s = 0; s < 2; s++) begin
         sel = s;
         unit_cfg();
         bsh[0][0] = 1; bsh[0][1] = 1;
         bfr[0][0] = 5; bsa[0][0] = 2;
         bofs = '0; aofs = '0;
         bofs[0] = 3; bofs[1] = 1;
         beg = 0; en = 1; skip = '0;
         run_txn(0);
         e = gm[0][1] + 32'd61;
         checks++;
         if (first_mofs[1] !== e) begin
            errors++;
            $display("FAIL stride_sum%0d: %h, required %h", s, first_mofs[1], e);
         end
         bfr[0][0] = 1; bsa[0][0] = 0;
         bofs = '0;
         bofs[0] = '1; bofs[1] = 1;
         run_txn(0);
         e = gm[0][1];
         checks++;
         if (first_mofs[1] !== e) begin
            errors++;
            $display("FAIL stride_wrap%0d: %h, required %h", s, first_mofs[1], e);
         end
      end
   endtask

   task automatic test_random(input int s, input int cnt, input int stall);
      sel = s;
      for (int t = 0; t < cnt; t++) begin
         rand_cfg();
         for (int i = 0; i < VDIM; i++) begin
            bofs[i] = $urandom;
            aofs[i] = $urandom;
         end
         beg  = ICFG_BW'($urandom_range(N_ICFG));
         en   = ICFG_BW'($urandom_range(N_ICFG));
         skip = N_ICFG'($urandom);
         run_txn(stall);
      end
   endtask

   task automatic test_reset_mid();
      for (int s = 0; s < 2; s++) begin
         sel = s;
         rand_cfg();
         for (int i = 0; i < VDIM; i++) bofs[i] = $urandom;
         beg = 0; en = 4; skip = '0;
         mofs_ack = 1'b0;
         @(negedge clk);
         abofs_rdy = 1'b1;
         repeat (1 + s) @(negedge clk);
         #1;
         checks++;
         if (mofs_rdy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy%0d: rdy=%b, required 1", s, mofs_rdy);
         end
         rst = 1'b1;
         abofs_rdy = 1'b0;
         @(negedge clk);
         #1;
         checks++;
         if ({mofs_rdy, abofs_ack, o_last} !== 3'b000 || o_id !== '0
             || mofs !== '0) begin
            errors++;
            $display("FAIL mid_reset%0d: rdy=%b ack=%b last=%b id=%0d mofs=%h, required all 0",
               s, mofs_rdy, abofs_ack, o_last, o_id, mofs);
         end
         rst = 1'b0;
         beg = 2; en = 4; skip = '0;
         run_txn(20);
      end
   endtask

   initial begin
      abofs_rdy = 1'b0;
      mofs_ack = 1'b0;
      sel = 0;
      bofs = '0; aofs = '0;
      beg = '0; en = '0; skip = '0;
      unit_cfg();
      test_reset();
      test_basic();
      test_empty();
      test_stride();
      test_random(0, 25, 0);
      test_random(0, 25, 40);
      test_random(1, 25, 0);
      test_random(1, 30, 40);
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
